// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_if
//  Description : Bundle of the two requester handshakes, their read-response
//                channels and the single RAM port driven by the arbiter.
//                slave  modport : the arbiter side
//                master modport : requesters + RAM (environment side)
//  Ports       : req{0,1}_valid/ready/we/addr/wdata/lock - request channels
//                rsp{0,1}_valid/rdata                    - read responses
//                ram_a/ram_d/ram_wr/ram_q                - RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_lock;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_lock;

    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;

    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_wr;
    logic [DW-1:0] ram_q;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output ram_a, ram_d, ram_wr,
        input  ram_q
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  ram_a, ram_d, ram_wr,
        output ram_q
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Two-requester round-robin arbiter in front of one RAM port.
//                Supports bounded burst locking (MAX_BURST consecutive grants),
//                issues registered RAM commands and routes the RAM's
//                combinational read data back to the issuing requester two
//                cycles after the handshake.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - ram_port_arbiter_if.slave (requests, responses, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int AW        = 7,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  wire                   clk,
    input  wire                   rst_n,
    ram_port_arbiter_if.slave     bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_burst_cnt;
    logic [CW-1:0] w_burst_cnt_nxt;
    logic          r_last_grant;
    logic          w_last_grant_nxt;

    // Grant decision (combinational outputs of the FSM)
    logic          w_grant0;
    logic          w_grant1;
    logic          w_arb_last;

    // Selected request fields of the winning requester
    logic          w_hs;
    logic          w_sel;
    logic          w_sel_we;
    logic          w_sel_lock;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // Command stage (presented to the RAM) and response stage
    logic [AW-1:0] r_ram_a;
    logic [DW-1:0] r_ram_d;
    logic          r_ram_wr;
    logic          r_cmd_rd;
    logic          r_cmd_tag;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [DW-1:0] r_rsp0_rdata;
    logic [DW-1:0] r_rsp1_rdata;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= '0;
            r_last_grant <= 1'b1;     // requester 0 wins the first tie
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: output logic (grants / ready)
    //
    // While a requester owns the port and still has burst budget it keeps
    // the grant. Otherwise the cycle is arbitrated like IDLE. On a forced
    // release the owner is treated as the last winner so the other side
    // gets priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        w_arb_last = r_last_grant;

        if (r_state == ST_OWN0 && bus.req0_valid && r_burst_cnt < C_MAX_CNT) begin
            w_grant0 = 1'b1;
        end else if (r_state == ST_OWN1 && bus.req1_valid && r_burst_cnt < C_MAX_CNT) begin
            w_grant1 = 1'b1;
        end else begin
            if (r_state == ST_OWN0 && r_burst_cnt == C_MAX_CNT) begin
                w_arb_last = 1'b0;
            end else if (r_state == ST_OWN1 && r_burst_cnt == C_MAX_CNT) begin
                w_arb_last = 1'b1;
            end

            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = w_arb_last;
                w_grant1 = !w_arb_last;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    // A grant is only ever raised on a valid request, so a grant is a handshake.
    assign w_hs        = w_grant0 | w_grant1;
    assign w_sel       = w_grant1;
    assign w_sel_we    = w_sel ? bus.req1_we    : bus.req0_we;
    assign w_sel_lock  = w_sel ? bus.req1_lock  : bus.req0_lock;
    assign w_sel_addr  = w_sel ? bus.req1_addr  : bus.req0_addr;
    assign w_sel_wdata = w_sel ? bus.req1_wdata : bus.req0_wdata;

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    //
    // Any cycle without a handshake, or a handshake without lock, drops
    // ownership. A locked handshake extends the burst when the same owner
    // still has budget; a regrant after forced release starts a new burst.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = ST_IDLE;
        w_burst_cnt_nxt  = '0;
        w_last_grant_nxt = r_last_grant;

        if (w_hs) begin
            w_last_grant_nxt = w_sel;
            if (w_sel_lock) begin
                w_state_nxt = w_sel ? ST_OWN1 : ST_OWN0;
                if (r_state == w_state_nxt && r_burst_cnt < C_MAX_CNT) begin
                    w_burst_cnt_nxt = r_burst_cnt + C_ONE;
                end else begin
                    w_burst_cnt_nxt = C_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command stage: registered RAM command, issued the cycle after the
    // handshake. Address and data hold on idle cycles; only the write
    // strobe is cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_a   <= '0;
            r_ram_d   <= '0;
            r_ram_wr  <= 1'b0;
            r_cmd_rd  <= 1'b0;
            r_cmd_tag <= 1'b0;
        end else if (w_hs) begin
            r_ram_a   <= w_sel_addr;
            r_ram_d   <= w_sel_wdata;
            r_ram_wr  <= w_sel_we;
            r_cmd_rd  <= !w_sel_we;
            r_cmd_tag <= w_sel;
        end else begin
            r_ram_wr  <= 1'b0;
            r_cmd_rd  <= 1'b0;
        end
    end

    assign bus.ram_a  = r_ram_a;
    assign bus.ram_d  = r_ram_d;
    assign bus.ram_wr = r_ram_wr;

    // ------------------------------------------------------------------
    // Response stage: ram_q is valid for the address being presented, so
    // it is captured at the end of the command cycle and returned to the
    // tagged requester as a one-cycle pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= r_cmd_rd && !r_cmd_tag;
            r_rsp1_valid <= r_cmd_rd &&  r_cmd_tag;
            if (r_cmd_rd && !r_cmd_tag) begin
                r_rsp0_rdata <= bus.ram_q;
            end
            if (r_cmd_rd && r_cmd_tag) begin
                r_rsp1_rdata <= bus.ram_q;
            end
        end
    end

    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_rdata = r_rsp0_rdata;
    assign bus.rsp1_rdata = r_rsp1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter. Provides a RAM
//                model, a transaction-level reference of the arbitration and
//                read-return rules, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic clk;
    logic rst_n;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, synchronous write
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign bus.ram_q = mem[bus.ram_a];
    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_a] <= bus.ram_d;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Reference model (transaction level)
    // ------------------------------------------------------------------
    int            m_owner;     // -1: nobody holds a lock
    int            m_run;       // consecutive locked grants of m_owner
    int            m_last;      // last granted requester
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    // command being presented this cycle
    bit            c_valid;
    bit            c_we;
    int            c_tag;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    // response expected this cycle
    bit            r_valid;
    int            r_tag;
    logic [DW-1:0] hold [0:1];

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        c_valid = 1'b0;
        r_valid = 1'b0;
        hold[0] = '0;
        hold[1] = '0;
    endtask

    function automatic int pick(bit v0, bit v1);
        int  pref;
        bit  vo;
        pref = m_last;
        if (m_owner >= 0) begin
            vo = (m_owner == 0) ? v0 : v1;
            if (vo && m_run < MAXB) return m_owner;
            if (m_run >= MAXB) pref = m_owner;
        end
        if (v0 && v1) return 1 - pref;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit we0, input bit lk0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input bit lk1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_lock = lk0;
        bus.req0_addr  = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_lock = lk1;
        bus.req1_addr  = a1; bus.req1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // One clock cycle: called just after a rising edge, checks outputs at the
    // falling edge, advances the model and returns just after the next rising
    // edge. g reports the observed grant (-1 none, 2 both).
    task automatic step(output int g);
        int            mg;
        bit            lk;
        logic [DW-1:0] rd;
        @(negedge clk);
        mg = pick(bus.req0_valid, bus.req1_valid);
        chk("ready0", 32'(bus.req0_ready), 32'(mg == 0));
        chk("ready1", 32'(bus.req1_ready), 32'(mg == 1));
        chk("ram_wr", 32'(bus.ram_wr), 32'(c_valid && c_we));
        if (c_valid) chk("ram_a", 32'(bus.ram_a), 32'(c_addr));
        if (c_valid && c_we) chk("ram_d", 32'(bus.ram_d), 32'(c_data));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(r_valid && r_tag == 0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(r_valid && r_tag == 1));
        chk("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(hold[0]));
        chk("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(hold[1]));

        if (bus.req0_ready && bus.req1_ready) g = 2;
        else if (bus.req0_ready) g = 0;
        else if (bus.req1_ready) g = 1;
        else g = -1;

        // response stage follows from the command presented now
        r_valid = 1'b0;
        if (c_valid) begin
            if (c_we) begin
                shadow[c_addr] = c_data;
            end else begin
                rd = shadow[c_addr];
                r_valid = 1'b1;
                r_tag   = c_tag;
                hold[c_tag] = rd;
            end
        end
        // command stage and arbitration state follow from this cycle's grant
        c_valid = (mg >= 0);
        if (mg >= 0) begin
            c_tag  = mg;
            c_we   = (mg == 0) ? bus.req0_we    : bus.req1_we;
            c_addr = (mg == 0) ? bus.req0_addr  : bus.req1_addr;
            c_data = (mg == 0) ? bus.req0_wdata : bus.req1_wdata;
            lk     = (mg == 0) ? bus.req0_lock  : bus.req1_lock;
            if (lk) begin
                m_run   = (m_owner == mg && m_run < MAXB) ? m_run + 1 : 1;
                m_owner = mg;
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
            m_last = mg;
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int g;
        int exp_lock [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = 8'(i * 3 + 1);
            shadow[i] = 8'(i * 3 + 1);
        end
        mem[5]    = 8'hA5;
        shadow[5] = 8'hA5;
        model_reset();
        idle();
        rst_n = 1'b0;

        // Reset held: toggle inputs, every output stays cleared
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom));
            @(negedge clk);
            chk("rst_ram_wr", 32'(bus.ram_wr), 0);
            chk("rst_ram_a", 32'(bus.ram_a), 0);
            chk("rst_ram_d", 32'(bus.ram_d), 0);
            chk("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
            chk("rst_rsp_rdata", 32'({bus.rsp1_rdata, bus.rsp0_rdata}), 0);
        end
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First tie after reset goes to requester 0
        drive(1, 0, 0, 7'h01, 8'h00, 1, 0, 0, 7'h02, 8'h00);
        step(g);
        chk("first_tie", 32'(g), 0);
        idle();
        step(g);
        step(g);

        // Single read of 0x05 by requester 0
        drive(1, 0, 0, 7'h05, 8'h00, 0, 0, 0, '0, '0);
        step(g);
        idle();
        chk("sr_ram_a", 32'(bus.ram_a), 32'h05);
        chk("sr_ram_wr", 32'(bus.ram_wr), 0);
        step(g);
        chk("sr_rsp0_valid", 32'(bus.rsp0_valid), 1);
        chk("sr_rsp0_rdata", 32'(bus.rsp0_rdata), 32'hA5);
        chk("sr_rsp1_valid", 32'(bus.rsp1_valid), 0);
        step(g);

        // Write 0x7F <- 0x3C then read it back the following cycle
        drive(0, 0, 0, '0, '0, 1, 1, 0, 7'h7F, 8'h3C);
        step(g);
        chk("wr_ram_wr", 32'(bus.ram_wr), 1);
        drive(0, 0, 0, '0, '0, 1, 0, 0, 7'h7F, 8'h00);
        step(g);
        chk("wr_ram_wr_drop", 32'(bus.ram_wr), 0);
        idle();
        step(g);
        chk("wr_rsp1_valid", 32'(bus.rsp1_valid), 1);
        chk("wr_rsp1_rdata", 32'(bus.rsp1_rdata), 32'h3C);
        step(g);

        // Round-robin with both requesters always valid
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 7'($urandom), 8'h00, 1, 0, 0, 7'($urandom), 8'h00);
            step(g);
            chk("rr_grant", 32'(g), 32'(i % 2));
        end
        idle();
        step(g);
        step(g);

        // Locked burst against a competing requester, then uncontended
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 7'($urandom), 8'h00, 1, 0, 0, 7'($urandom), 8'h00);
            step(g);
            chk("lock_grant", 32'(g), 32'(exp_lock[i]));
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 1'($urandom), 1, 7'($urandom), 8'($urandom), 0, 0, 0, '0, '0);
            step(g);
            chk("lock_solo", 32'(g), 0);
        end

        // Lock lapse: owner drops valid for one cycle
        drive(0, 0, 1, '0, '0, 1, 0, 0, 7'h10, 8'h00);
        step(g);
        chk("lapse_grant", 32'(g), 1);
        drive(1, 0, 1, 7'h11, 8'h00, 0, 0, 0, '0, '0);
        step(g);
        drive(1, 1, 1, 7'h12, 8'h99, 0, 0, 0, '0, '0);
        step(g);
        chk("mid_ram_wr_pre", 32'(bus.ram_wr), 1);
        chk("mid_rsp0_pre", 32'(bus.rsp0_valid), 1);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ram_wr", 32'(bus.ram_wr), 0);
        chk("mid_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(g);
            chk("post_rst_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  7'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  7'($urandom_range(0, 7)), 8'($urandom));
            step(g);
        end
        idle();
        step(g);
        step(g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
